// File: rtl/line_data_memory.sv
// Line-granular backing data memory: one 256-bit line read or write per request, fixed access latency.
// Latency: ack_o rises LATENCY edges after acceptance and stays high for exactly one cycle.
// Backpressure: one request in flight; enable_i is ignored while busy_o is high (BUSY and ACK).
//
// Ports:
//   clk_i     - single clock, all state changes on the rising edge
//   rst_i     - synchronous active-high reset (memory array contents are kept)
//   addr_i    - byte address; line index = addr_i[DEPTH_LOG2+4:5], other bits alias
//   data_i    - write line, latched at acceptance
//   enable_i  - request valid, sampled only in IDLE
//   write_i   - 1 = write, 0 = read, latched at acceptance
//   ack_o     - one-cycle completion pulse
//   data_o    - read line, updated only on read commits and held otherwise
//   busy_o    - high from acceptance through the ack cycle

module line_data_memory #(
    parameter int LATENCY    = 10,
    parameter int DEPTH_LOG2 = 9,
    parameter int LINE_W     = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output logic              busy_o
);

    localparam int             DEPTH    = 1 << DEPTH_LOG2;
    // Counter value on the commit edge; the counter is cleared at acceptance
    // so the commit lands exactly LATENCY edges after the accepting edge.
    localparam logic [7:0]     LAST_CNT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    ack_q, ack_d;
    logic                    busy_q, busy_d;
    logic [LINE_W-1:0]       rdat_q, rdat_d;

    // Request captured at acceptance; later input changes are ignored.
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic                    wr_q, wr_d;
    logic [LINE_W-1:0]       wdat_q, wdat_d;

    logic [LINE_W-1:0]       mem_array [DEPTH];

    logic                    commit;
    logic                    commit_wr;

    // Offset bits and bits above the index only alias lines.
    logic                    unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:DEPTH_LOG2+5], addr_i[4:0]};

    assign commit    = (state_q == ST_BUSY) && (cnt_q == LAST_CNT);
    // Reset on the commit edge wins, so the write is suppressed too.
    assign commit_wr = commit && wr_q && !rst_i;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = ack_q;
        rdat_d  = rdat_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdat_d  = wdat_q;

        case (state_q)
            ST_IDLE: begin
                ack_d = 1'b0;
                if (enable_i) begin
                    state_d = ST_BUSY;
                    cnt_d   = 8'd0;
                    idx_d   = addr_i[DEPTH_LOG2+4:5];
                    wr_d    = write_i;
                    wdat_d  = data_i;
                end
            end
            ST_BUSY: begin
                if (commit) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    // Read data is sampled on the commit edge, so a write to the
                    // same line that finished earlier is already visible here.
                    if (!wr_q) begin
                        rdat_d = mem_array[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_ACK: begin
                // enable_i deliberately not looked at: a held request is taken
                // on the first IDLE edge, giving LATENCY+2 edge spacing.
                state_d = ST_IDLE;
                ack_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                ack_d   = 1'b0;
            end
        endcase

        // busy_o reflects the registered state, so it is precomputed from state_d.
        busy_d = (state_d != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Control flops (FSM with registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            rdat_q  <= rdat_d;
        end
    end

    // ------------------------------------------------------------------
    // Request capture (no reset needed: only used after an acceptance)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        idx_q  <= idx_d;
        wr_q   <= wr_d;
        wdat_q <= wdat_d;
    end

    // ------------------------------------------------------------------
    // Line storage, not cleared by reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (commit_wr) begin
            mem_array[idx_q] <= wdat_q;
        end
    end

    assign ack_o  = ack_q;
    assign busy_o = busy_q;
    assign data_o = rdat_q;

endmodule

// File: tb/tb_line_data_memory.sv
module tb_line_data_memory;

    localparam int LAT = 10;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         enable_i;
    logic         write_i;
    logic         ack_o;
    logic [255:0] data_o;
    logic         busy_o;

    line_data_memory #(
        .LATENCY    (LAT),
        .DEPTH_LOG2 (9),
        .LINE_W     (256)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .ack_o    (ack_o),
        .data_o   (data_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic         is_wr;
        logic [255:0] dat;
        int           ack_cyc;
    } exp_t;

    exp_t         sb[$];
    logic [255:0] mdl [512];
    logic [255:0] last_rd_m;
    int           cyc = 0;
    int           e0;
    int           checks = 0;
    int           failures = 0;
    logic         prev_ack = 1'b0;

    localparam logic [255:0] PAT3 = {32{8'hA5}};
    localparam logic [255:0] PAT4 = {8{32'h4444_0004}};
    localparam logic [255:0] PAT5 = {8{32'h5555_0005}};
    localparam logic [255:0] PAT6 = {8{32'h6666_0006}};
    localparam logic [255:0] PAT7 = {8{32'h7777_0007}};
    localparam logic [255:0] WDAT = 256'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321_1357_9BDF_2468_ACE0_CAFE_F00D_DEAD_0001;
    localparam logic [255:0] ADAT = {8{32'hA11A_5001}};

    task automatic check_val(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(posedge clk_i) cyc++;

    // Scoreboard monitor: every ack must match the oldest outstanding request.
    always begin
        exp_t e;
        @(posedge clk_i);
        #1;
        if (prev_ack) check_val("ack_one_cycle", ack_o, 1'b0);
        if (ack_o === 1'b1) begin
            if (sb.size() == 0) begin
                check_val("unexpected_ack", ack_o, 1'b0);
            end else begin
                e = sb.pop_front();
                check_val(e.is_wr ? "wr_ack_cycle" : "rd_ack_cycle", cyc, e.ack_cyc);
                check_val(e.is_wr ? "wr_data_o_hold" : "rd_data_o", data_o, e.dat);
            end
        end
        prev_ack = (ack_o === 1'b1);
    end

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[13:5]);
    endfunction

    task automatic push_exp(input logic [31:0] a, input logic wr, input logic [255:0] d, input int ack_cyc);
        exp_t e;
        e.is_wr = wr;
        e.ack_cyc = ack_cyc;
        if (wr) begin
            mdl[idx_of(a)] = d;
            e.dat = last_rd_m;
        end else begin
            last_rd_m = mdl[idx_of(a)];
            e.dat = last_rd_m;
        end
        sb.push_back(e);
    endtask

    // Drive one request from IDLE; returns at the falling edge after acceptance.
    task automatic issue(input logic [31:0] a, input logic wr, input logic [255:0] d, input bit push);
        @(negedge clk_i);
        addr_i = a;
        write_i = wr;
        data_i = d;
        enable_i = 1'b1;
        @(posedge clk_i);
        #1;
        e0 = cyc;
        check_val("accept", busy_o, 1'b1);
        if (push) push_exp(a, wr, d, e0 + LAT);
        @(negedge clk_i);
        enable_i = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i);
            #1;
            if (!busy_o) break;
        end
        check_val("idle", busy_o, 1'b0);
    endtask

    // Assert reset on edge E0+k of the request just issued.
    task automatic reset_at(input int k);
        repeat (k - 1) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check_val("rst_busy", busy_o, 1'b0);
        check_val("rst_ack", ack_o, 1'b0);
        check_val("rst_data_o", data_o, '0);
        last_rd_m = '0;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int acc;
        logic prev_busy;

        rst_i = 1'b1;
        enable_i = 1'b1;
        write_i = 1'b0;
        addr_i = 32'h0;
        data_i = '0;
        last_rd_m = '0;

        // Reset held with a pending request: nothing accepted.
        repeat (2) begin
            @(posedge clk_i);
            #1;
            check_val("reset_ack", ack_o, 1'b0);
            check_val("reset_busy", busy_o, 1'b0);
            check_val("reset_data_o", data_o, '0);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        enable_i = 1'b0;
        @(posedge clk_i);
        #1;
        check_val("idle_after_reset", busy_o, 1'b0);

        // Preload through the write port.
        issue(32'h60, 1'b1, PAT3, 1'b1); wait_idle();
        issue(32'h80, 1'b1, PAT4, 1'b1); wait_idle();
        issue(32'hA0, 1'b1, PAT5, 1'b1); wait_idle();
        issue(32'hC0, 1'b1, PAT6, 1'b1); wait_idle();
        issue(32'hE0, 1'b1, PAT7, 1'b1); wait_idle();

        // Read latency of line 3.
        issue(32'h60, 1'b0, '0, 1'b1); wait_idle();

        // Write with enable held through ack, then read of the same line.
        @(negedge clk_i);
        addr_i = 32'h1FE0;
        write_i = 1'b1;
        data_i = WDAT;
        enable_i = 1'b1;
        @(posedge clk_i);
        #1;
        e0 = cyc;
        check_val("held_accept", busy_o, 1'b1);
        push_exp(32'h1FE0, 1'b1, WDAT, e0 + LAT);
        push_exp(32'h1FE0, 1'b0, '0, e0 + 2 * LAT + 2);
        @(negedge clk_i);
        write_i = 1'b0;
        data_i = '1;
        prev_busy = 1'b1;
        acc = -1;
        for (int i = 0; i < 30 && acc < 0; i++) begin
            @(posedge clk_i);
            #1;
            if (busy_o && !prev_busy) acc = cyc;
            prev_busy = busy_o;
        end
        check_val("b2b_accept_cycle", acc, e0 + LAT + 2);
        @(negedge clk_i);
        enable_i = 1'b0;
        wait_idle();

        // Aliasing: upper address bits and offset bits select the same line.
        issue(32'h0000_4020, 1'b1, ADAT, 1'b1); wait_idle();
        issue(32'h0000_003F, 1'b0, '0, 1'b1); wait_idle();

        // Input changes during BUSY are ignored.
        issue(32'hA0, 1'b0, '0, 1'b1);
        addr_i = 32'hC0;
        write_i = 1'b1;
        data_i = '1;
        enable_i = 1'b1;
        repeat (3) @(negedge clk_i);
        enable_i = 1'b0;
        wait_idle();
        issue(32'hC0, 1'b0, '0, 1'b1); wait_idle();

        // Reset mid-op: write to line 7 aborted.
        issue(32'hE0, 1'b1, '1, 1'b0);
        reset_at(5);
        wait_idle();
        repeat (15) @(posedge clk_i);
        issue(32'hE0, 1'b0, '0, 1'b1); wait_idle();

        // Reset exactly on the commit edge: no commit, no ack.
        issue(32'hE0, 1'b1, ~PAT7, 1'b0);
        reset_at(LAT);
        wait_idle();
        issue(32'hE0, 1'b0, '0, 1'b1); wait_idle();

        // Reset during ACK: committed write survives.
        issue(32'h80, 1'b1, ~PAT4, 1'b1);
        reset_at(LAT + 1);
        wait_idle();
        issue(32'h80, 1'b0, '0, 1'b1); wait_idle();

        repeat (3) @(posedge clk_i);
        #1;
        check_val("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
